// File: rtl/biriscv_trace_buf.sv
// Retire-trace capture buffer: filters retired lanes by PC window and queues
// {seq, gap, pc, opcode} records in a FIFO drained through a valid/ready port.
module biriscv_trace_buf #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [NUM_CH-1:0]     valid_i,
  input  logic [32*NUM_CH-1:0]  pc_i,
  input  logic [32*NUM_CH-1:0]  opcode_i,
  input  logic [31:0]           filt_lo_i,
  input  logic [31:0]           filt_hi_i,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output logic [31:0]           trace_pc_o,
  output logic [31:0]           trace_opcode_o,
  output logic [SEQ_W-1:0]      trace_seq_o,
  output logic                  trace_gap_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [SEQ_W-1:0] seq;
  logic [CNT_W-1:0] drop_cnt;
  logic             pending_gap;

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      op_mem  [DEPTH];
  logic [SEQ_W-1:0] seq_mem [DEPTH];
  logic [DEPTH-1:0] gap_mem;

  logic [NUM_CH-1:0] wr_en;
  logic [PTR_W-1:0]  wr_idx   [NUM_CH];
  logic [SEQ_W-1:0]  lane_seq [NUM_CH];
  logic [NUM_CH-1:0] lane_gap;
  logic [LVL_W-1:0]  free, push_cnt, drop_n, qual_cnt;
  logic [31:0]       lane_pc;
  logic              lane_qual;
  logic              pop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LVL_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Lane allocation: space is judged on the start-of-cycle level, so a pop
  // in the same cycle never makes room for this cycle's pushes.
  always_comb begin
    free      = LVL_W'(DEPTH) - level;
    push_cnt  = '0;
    drop_n    = '0;
    qual_cnt  = '0;
    lane_pc   = '0;
    lane_qual = 1'b0;
    wr_en     = '0;
    lane_gap  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      lane_pc     = pc_i[32*n +: 32];
      lane_qual   = enable_i & valid_i[n] & (lane_pc >= filt_lo_i) & (lane_pc <= filt_hi_i);
      wr_idx[n]   = wr_ptr + push_cnt[PTR_W-1:0];
      lane_seq[n] = seq + SEQ_W'(qual_cnt);
      lane_gap[n] = pending_gap & (push_cnt == '0);
      if (lane_qual) begin
        if (push_cnt < free) begin
          wr_en[n] = ~clear_i;
          push_cnt = push_cnt + LVL_W'(1);
        end else begin
          drop_n = drop_n + LVL_W'(1);
        end
        qual_cnt = qual_cnt + LVL_W'(1);
      end
    end
  end

  assign pop = (level != '0) & trace_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      seq         <= '0;
      drop_cnt    <= '0;
      pending_gap <= 1'b0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      seq         <= '0;
      drop_cnt    <= '0;
      pending_gap <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + push_cnt[PTR_W-1:0];
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      level    <= level + push_cnt - LVL_W'(pop);
      seq      <= seq + SEQ_W'(qual_cnt);
      drop_cnt <= sat_add(drop_cnt, drop_n);
      // A drop after this cycle's pushes re-arms the flag for a later push.
      if (drop_n != '0)
        pending_gap <= 1'b1;
      else if (push_cnt != '0)
        pending_gap <= 1'b0;
    end
  end

  // Record storage carries no reset; empty entries are masked at the output.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr_en[n]) begin
        pc_mem[wr_idx[n]]  <= pc_i[32*n +: 32];
        op_mem[wr_idx[n]]  <= opcode_i[32*n +: 32];
        seq_mem[wr_idx[n]] <= lane_seq[n];
        gap_mem[wr_idx[n]] <= lane_gap[n];
      end
    end
  end

  assign trace_valid_o  = (level != '0);
  assign trace_pc_o     = trace_valid_o ? pc_mem[rd_ptr]  : '0;
  assign trace_opcode_o = trace_valid_o ? op_mem[rd_ptr]  : '0;
  assign trace_seq_o    = trace_valid_o ? seq_mem[rd_ptr] : '0;
  assign trace_gap_o    = trace_valid_o & gap_mem[rd_ptr];
  assign level_o        = level;
  assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_biriscv_trace_buf.sv
// Directed bench for biriscv_trace_buf (NUM_CH=2, DEPTH=16).
module tb_biriscv_trace_buf;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic        clear_i;
  logic [1:0]  valid_i;
  logic [63:0] pc_i;
  logic [63:0] opcode_i;
  logic [31:0] filt_lo_i;
  logic [31:0] filt_hi_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_opcode_o;
  logic [15:0] trace_seq_o;
  logic        trace_gap_o;
  logic [4:0]  level_o;
  logic [15:0] drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  biriscv_trace_buf #(.NUM_CH(2), .DEPTH(16), .SEQ_W(16), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .valid_i(valid_i), .pc_i(pc_i), .opcode_i(opcode_i),
    .filt_lo_i(filt_lo_i), .filt_hi_i(filt_hi_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_opcode_o(trace_opcode_o),
    .trace_seq_o(trace_seq_o), .trace_gap_o(trace_gap_o),
    .level_o(level_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    valid_i  = v;
    pc_i     = {p1, p0};
    opcode_i = {p1 ^ 32'hA5A5_0000, p0 ^ 32'hA5A5_0000};
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, trace_valid_o, 0);
    check_val({tag, "_level"}, level_o, 0);
    check_val({tag, "_drop"}, drop_cnt_o, 0);
    check_val({tag, "_pc"}, trace_pc_o, 0);
    check_val({tag, "_seq"}, trace_seq_o, 0);
    check_val({tag, "_op"}, trace_opcode_o, 0);
    check_val({tag, "_gap"}, trace_gap_o, 0);
  endtask

  initial begin
    logic [15:0] pre_seq;
    logic [31:0] pre_pc;
    logic        pre_v, pre_r;
    int          exp_pop;

    rst_ni = 1'b0; enable_i = 1'b1; clear_i = 1'b0; trace_ready_i = 1'b0;
    filt_lo_i = 32'h0; filt_hi_i = 32'hFFFF_FFFF;
    drive(2'b00, 0, 0);
    #12;
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();

    // 1: two lanes in one cycle, then drain
    drive(2'b11, 32'h100, 32'h104);
    step();
    drive(2'b00, 0, 0);
    check_val("t1_level", level_o, 2);
    check_val("t1_pc0", trace_pc_o, 32'h100);
    check_val("t1_op0", trace_opcode_o, 32'hA5A5_0100);
    check_val("t1_seq0", trace_seq_o, 0);
    check_val("t1_gap0", trace_gap_o, 0);
    trace_ready_i = 1'b1;
    step();
    check_val("t1_seq1", trace_seq_o, 1);
    check_val("t1_pc1", trace_pc_o, 32'h104);
    step();
    trace_ready_i = 1'b0;
    check_val("t1_empty", trace_valid_o, 0);
    check_val("t1_pc_empty", trace_pc_o, 0);

    // 2: fill, overflow, then gap on the next pushed record
    do_clear();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h1000 + 8*i, 32'h1004 + 8*i);
      step();
    end
    check_val("t2_full", level_o, 16);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h1800, 32'h1804);
      step();
    end
    drive(2'b00, 0, 0);
    check_val("t2_level", level_o, 16);
    check_val("t2_drop", drop_cnt_o, 6);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    check_val("t2_level15", level_o, 15);
    drive(2'b01, 32'h2000, 0);
    step();
    drive(2'b00, 0, 0);
    check_val("t2_level16", level_o, 16);
    trace_ready_i = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check_val("t2_seq", trace_seq_o, i);
      check_val("t2_nogap", trace_gap_o, 0);
      step();
    end
    check_val("t2_gap_seq", trace_seq_o, 22);
    check_val("t2_gap", trace_gap_o, 1);
    check_val("t2_gap_pc", trace_pc_o, 32'h2000);
    step();
    trace_ready_i = 1'b0;
    check_val("t2_drained", level_o, 0);

    // 3: PC window filtering
    do_clear();
    filt_lo_i = 32'h200; filt_hi_i = 32'h2FF;
    drive(2'b11, 32'h1FC, 32'h200);
    step();
    check_val("t3_level", level_o, 1);
    check_val("t3_pc", trace_pc_o, 32'h200);
    check_val("t3_seq", trace_seq_o, 0);
    drive(2'b01, 32'h300, 0);
    step();
    check_val("t3_above", level_o, 1);
    filt_lo_i = 32'h300; filt_hi_i = 32'h200;
    drive(2'b11, 32'h250, 32'h300);
    step();
    drive(2'b00, 0, 0);
    check_val("t3_inverted", level_o, 1);
    filt_lo_i = 32'h0; filt_hi_i = 32'hFFFF_FFFF;

    // 4: pop does not free space for same-cycle pushes
    do_clear();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h3000 + 8*i, 32'h3004 + 8*i);
      step();
    end
    drive(2'b11, 32'h3800, 32'h3804);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    drive(2'b00, 0, 0);
    check_val("t4_level", level_o, 15);
    check_val("t4_drop", drop_cnt_o, 2);
    check_val("t4_head", trace_seq_o, 1);

    // 5: ready toggling under continuous single-lane pushes
    do_clear();
    exp_pop = 0;
    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 32'h4000 + 4*i, 0);
      trace_ready_i = i[0];
      pre_v = trace_valid_o; pre_r = trace_ready_i;
      pre_seq = trace_seq_o; pre_pc = trace_pc_o;
      step();
      if (pre_v && pre_r) begin
        check_val("t5_pop_seq", pre_seq, exp_pop);
        check_val("t5_pop_pc", pre_pc, 32'h4000 + 4*exp_pop);
        exp_pop++;
      end else if (pre_v) begin
        check_val("t5_stall_seq", trace_seq_o, pre_seq);
        check_val("t5_stall_pc", trace_pc_o, pre_pc);
      end
    end
    check_val("t5_level", level_o, 10);
    check_val("t5_pops", exp_pop, 10);
    trace_ready_i = 1'b1;
    do_clear();
    trace_ready_i = 1'b0;
    drive(2'b00, 0, 0);
    check_val("t5_clr_level", level_o, 0);
    check_val("t5_clr_valid", trace_valid_o, 0);
    drive(2'b01, 32'h5000, 0);
    step();
    drive(2'b00, 0, 0);
    check_val("t5_restart_seq", trace_seq_o, 0);
    check_val("t5_restart_pc", trace_pc_o, 32'h5000);

    // 6: drop counter saturation, then asynchronous reset mid-transfer
    do_clear();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h6000 + 8*i, 32'h6004 + 8*i);
      step();
    end
    drive(2'b11, 32'h7000, 32'h7004);
    for (int i = 0; i < 32767; i++) step();
    check_val("t6_near", drop_cnt_o, 16'hFFFE);
    step();
    check_val("t6_sat", drop_cnt_o, 16'hFFFF);
    step();
    check_val("t6_hold", drop_cnt_o, 16'hFFFF);
    trace_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_rst");
    #4;
    drive(2'b00, 0, 0);
    trace_ready_i = 1'b0;
    rst_ni = 1'b1;
    step();
    check_val("t6_post_level", level_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
